rf_write_arbiter: RTL



---
 rtl/rv_pkg.sv | 29 ++
 rtl/rf_write_arbiter_scoreboard.sv | 59 +++++
 rtl/rf_write_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared types and sizes for the register-file write path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xdata_t;
    typedef logic [NUM_REGS-1:0]   reg_vec_t;

    // Starvation tracker for refused MDU responses.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    // One-hot mask for a register index; used for scoreboard set/clear.
    function automatic reg_vec_t reg_onehot(input reg_addr_t idx);
        reg_vec_t v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rf_write_arbiter_scoreboard.sv
// Per-register pending-write scoreboard for in-flight MDU destinations.
// Latency: set/clear visible one cycle later; read ports are combinational on registered state.
// Backpressure: none; set/clear are accepted every cycle.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   set_en/set_rd           mark a register pending (issue handshake)
//   clr_en/clr_rd           clear a pending register (response handshake)
//   rd_a/b/c_idx -> rd_a/b/c  three lookup ports (rs1, rs2, rd of decode)
//   pending                 full registered pending vector
module rf_scoreboard
    import rv_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_rd,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_rd,
    input  logic [REG_ADDR_W-1:0] rd_a_idx,
    input  logic [REG_ADDR_W-1:0] rd_b_idx,
    input  logic [REG_ADDR_W-1:0] rd_c_idx,
    output logic                  rd_a,
    output logic                  rd_b,
    output logic                  rd_c,
    output logic [NUM_REGS-1:0]   pending
);

    reg_vec_t pending_q;
    reg_vec_t pending_d;

    // Clear first, then set: a new issue to a register whose previous
    // result retires in the same cycle must stay pending.
    always_comb begin
        pending_d = pending_q;
        if (clr_en) begin
            pending_d = pending_d & ~reg_onehot(clr_rd);
        end
        if (set_en) begin
            pending_d = pending_d | reg_onehot(set_rd);
        end
        // x0 is hardwired; never track it.
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign rd_a    = pending_q[rd_a_idx];
    assign rd_b    = pending_q[rd_b_idx];
    assign rd_c    = pending_q[rd_c_idx];
    assign pending = pending_q;

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single RF write port between pipeline writeback and the MDU, tracks MDU hazards.
// Latency: write port is combinational (0 cycles); scoreboard/counter/FSM state updates next cycle.
// Backpressure: WB always wins; MDU response is refused while WB writes, and a forced decode stall drains WB after STARVE_LIMIT refusals.
//
// Ports:
//   clk, reset                              clock, synchronous active-high reset
//   wb_valid/wb_rd/wb_data                  pipeline writeback request
//   issue_valid/issue_rd -> issue_ready     MDU op issue handshake
//   mdu_resp_valid/rd/data -> mdu_resp_ready MDU result handshake
//   id_valid/id_rs1/id_rs2/id_rd/id_uses_*  decode-stage operands for hazard check
//   stall_id                                freeze IF/ID
//   rf_we/rf_waddr/rf_wdata                 register-file write port
module rf_write_arbiter
    import rv_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic                  issue_ready,
    input  logic                  mdu_resp_valid,
    input  logic [REG_ADDR_W-1:0] mdu_resp_rd,
    input  logic [XLEN-1:0]       mdu_resp_data,
    output logic                  mdu_resp_ready,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    output logic                  stall_id,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata
);

    localparam int CNT_W    = $clog2(MAX_OUTSTANDING + 1);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0]    MAX_CNT    = CNT_W'(MAX_OUTSTANDING);
    localparam logic [STARVE_W-1:0] LIMIT_CNT  = STARVE_W'(STARVE_LIMIT);
    localparam logic [STARVE_W-1:0] STARVE_ONE = STARVE_W'(1);

    // ------------------------------------------------------------------
    // Write port mux. A WB write to x0 is a no-op and must not steal the
    // port from the MDU.
    // ------------------------------------------------------------------
    logic wb_eff;
    logic resp_hs;
    logic issue_hs;

    always_comb begin
        wb_eff         = wb_valid && (wb_rd != '0);
        mdu_resp_ready = !wb_eff;
        rf_we          = 1'b0;
        rf_waddr       = '0;
        rf_wdata       = '0;
        if (wb_eff) begin
            rf_we    = 1'b1;
            rf_waddr = wb_rd;
            rf_wdata = wb_data;
        end else if (mdu_resp_valid && (mdu_resp_rd != '0)) begin
            // Responses to x0 are accepted but never written.
            rf_we    = 1'b1;
            rf_waddr = mdu_resp_rd;
            rf_wdata = mdu_resp_data;
        end
    end

    assign resp_hs = mdu_resp_valid && mdu_resp_ready;

    // ------------------------------------------------------------------
    // Scoreboard of pending MDU destinations.
    // ------------------------------------------------------------------
    logic     pend_rs1;
    logic     pend_rs2;
    logic     pend_rd;
    reg_vec_t pending;

    rf_scoreboard u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_en   (issue_hs),
        .set_rd   (issue_rd),
        .clr_en   (resp_hs),
        .clr_rd   (mdu_resp_rd),
        .rd_a_idx (id_rs1),
        .rd_b_idx (id_rs2),
        .rd_c_idx (id_rd),
        .rd_a     (pend_rs1),
        .rd_b     (pend_rs2),
        .rd_c     (pend_rd),
        .pending  (pending)
    );

    // ------------------------------------------------------------------
    // Outstanding counter. Issue is blocked at the cap and when the same
    // destination is still pending (WAW against an older MDU op).
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] outstanding_q;
    logic [CNT_W-1:0] outstanding_d;

    assign issue_ready = (outstanding_q < MAX_CNT) && !pending[issue_rd];
    assign issue_hs    = issue_valid && issue_ready;

    always_comb begin
        outstanding_d = outstanding_q;
        unique case ({issue_hs, resp_hs})
            2'b10: begin
                if (outstanding_q < MAX_CNT) begin
                    outstanding_d = outstanding_q + CNT_W'(1);
                end
            end
            2'b01: begin
                // A stray response with nothing in flight must not wrap.
                if (outstanding_q != '0) begin
                    outstanding_d = outstanding_q - CNT_W'(1);
                end
            end
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

    // ------------------------------------------------------------------
    // Starvation FSM. Counts consecutive refused response cycles; once the
    // limit is hit, decode is frozen so WB empties and the MDU gets the port.
    // ------------------------------------------------------------------
    arb_state_t          state_q;
    arb_state_t          state_d;
    logic [STARVE_W-1:0] starve_cnt_q;
    logic [STARVE_W-1:0] starve_cnt_d;

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (mdu_resp_valid && !mdu_resp_ready) begin
                    starve_cnt_d = STARVE_ONE;
                    state_d      = (STARVE_ONE >= LIMIT_CNT) ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                // A withdrawn response is a protocol violation; just rearm.
                if (resp_hs || !mdu_resp_valid) begin
                    starve_cnt_d = '0;
                    state_d      = IDLE;
                end else begin
                    starve_cnt_d = starve_cnt_q + STARVE_ONE;
                    if (starve_cnt_d >= LIMIT_CNT) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (resp_hs) begin
                    starve_cnt_d = '0;
                    state_d      = IDLE;
                end
            end
            default: begin
                starve_cnt_d = '0;
                state_d      = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Decode stall: RAW on used sources, WAW on the destination, or drain.
    // ------------------------------------------------------------------
    logic haz;

    assign haz      = id_valid && ((id_uses_rs1 && pend_rs1) ||
                                   (id_uses_rs2 && pend_rs2) ||
                                   pend_rd);
    assign stall_id = haz || (state_q == DRAIN);

endmodule
